ram_shift_tap_reader: RTL and testbench

RAM_SHIFT_TAP_READER -- requirements
Module: ram_shift_tap_reader

---
 rtl/ram_shift_tap_reader.sv | 136 +++++++++++++
 tb/tb_ram_shift_tap_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ram_shift_tap_reader.sv
// ram_shift_tap_reader
//   Programmable-delay tap on a circular sample RAM. Every accepted sample is
//   written at wr_ptr. On the same edge, the sample accepted D accepts earlier
//   is read back. D is the effective tap: Tap, clamped to 1..DEPTH-1. A history
//   count gates Q_valid so that a sample is only emitted once real history exists.
//
// Ports
//   Clock      in   rising-edge clock
//   Reset      in   asynchronous, active-high reset
//   Din_valid  in   sample accept strobe
//   Din        in   [DSIZE-1:0] sample written on accept
//   Flush      in   synchronous history clear; wins over Din_valid
//   Tap        in   [ASIZE-1:0] requested delay, in accepted samples
//   Q          out  [DSIZE-1:0] delayed sample (held between valid strobes)
//   Q_valid    out  one-cycle strobe: Q holds a real delayed sample
//   Tap_err    out  registered flag: Tap was clamped on the last edge
//
// Build option
//   RAM_SHIFT_TAP_OREG_EN : adds one output register stage on Q, Q_valid and
//                           Tap_err. This stage resets to 0. With it, latency
//                           is accept+2 edges; without it, latency is 1 edge.

module ram_shift_tap_reader #(
   parameter int DSIZE = 8,
   parameter int DEPTH = 16,
   parameter int ASIZE = $clog2(DEPTH)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Din_valid,
   input  logic [DSIZE-1:0] Din,
   input  logic             Flush,
   input  logic [ASIZE-1:0] Tap,
   output logic [DSIZE-1:0] Q,
   output logic             Q_valid,
   output logic             Tap_err
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {EMPTY, FILL, RUN} state_t;

   state_t           state, state_next;
   logic [DSIZE-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_addr, h, h_next, d_eff;
   logic             accept, clamp, emit;
   logic [DSIZE-1:0] q_core;
   logic             qv_core, err_core;

   // Effective delay: 0 maps to 1, anything beyond DEPTH-1 maps to DEPTH-1.
   always_comb begin
      clamp = 1'b0;
      d_eff = AW'(Tap);
      if (Tap == '0) begin
         clamp = 1'b1;
         d_eff = AW'(1);
      end else if (int'(Tap) > DEPTH - 1) begin
         clamp = 1'b1;
         d_eff = AW'(DEPTH - 1);
      end
   end

   assign accept  = Din_valid & ~Flush;
   // D >= 1, so the read address never equals the address written this edge.
   assign rd_addr = wr_ptr - d_eff;
   // The comparison uses the history before this accept, so a Tap change
   // takes effect on the very accept in which it is sampled.
   assign emit    = accept && (state != EMPTY) && (h >= d_eff);

   always_comb begin
      h_next = h;
      if (Flush)
         h_next = '0;
      else if (accept && (h != AW'(DEPTH - 1)))
         h_next = h + AW'(1);
   end

   always_comb begin
      state_next = state;
      if (Flush) begin
         state_next = EMPTY;
      end else begin
         case (state)
            EMPTY:   if (accept) state_next = (d_eff == AW'(1)) ? RUN : FILL;
            FILL:    if (h_next >= d_eff) state_next = RUN;
            RUN:     if (h_next < d_eff) state_next = FILL;
            default: state_next = EMPTY;
         endcase
      end
   end

   // Sample storage: not reset; history validity is tracked by h alone.
   always_ff @(posedge Clock) begin
      if (accept)
         mem[wr_ptr] <= Din;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state    <= EMPTY;
         wr_ptr   <= '0;
         h        <= '0;
         q_core   <= '0;
         qv_core  <= 1'b0;
         err_core <= 1'b0;
      end else begin
         state    <= state_next;
         h        <= h_next;
         err_core <= clamp;
         qv_core  <= emit;
         if (accept)
            wr_ptr <= wr_ptr + AW'(1);
         if (emit)
            q_core <= mem[rd_addr];
      end
   end

`ifdef RAM_SHIFT_TAP_OREG_EN
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Q       <= '0;
         Q_valid <= 1'b0;
         Tap_err <= 1'b0;
      end else begin
         Q       <= q_core;
         Q_valid <= qv_core;
         Tap_err <= err_core;
      end
   end
`else
   assign Q       = q_core;
   assign Q_valid = qv_core;
   assign Tap_err = err_core;
`endif

endmodule

// File: tb/tb_ram_shift_tap_reader.sv
`timescale 1ns/1ps

module tb_ram_shift_tap_reader;

   logic       Clock;
   logic       Reset;
   logic       Din_valid;
   logic [7:0] Din;
   logic       Flush;
   logic [3:0] Tap;
   logic [7:0] Q;
   logic       Q_valid;
   logic       Tap_err;

   int tests = 0;
   int fails = 0;

   ram_shift_tap_reader #(.DSIZE(8), .DEPTH(16)) dut (
      .Clock(Clock), .Reset(Reset), .Din_valid(Din_valid), .Din(Din),
      .Flush(Flush), .Tap(Tap), .Q(Q), .Q_valid(Q_valid), .Tap_err(Tap_err)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
      $fatal(1);
   end

   task automatic do_reset();
      Din_valid = 1'b0;
      Flush     = 1'b0;
      Din       = 8'h00;
      Reset     = 1'b1;
      #100;
      @(negedge Clock);
      Reset = 1'b0;
   endtask

   task automatic cycle(input logic v, input logic [7:0] d, input logic f);
      @(negedge Clock);
      Din_valid = v;
      Din       = d;
      Flush     = f;
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      Tap = 4'd4;
      do_reset();
      tests++; if (Q !== 8'h00)    begin fails++; $display("FAIL reset_q got %h exp 00", Q); end
      tests++; if (Q_valid !== 1'b0) begin fails++; $display("FAIL reset_qv got %b exp 0", Q_valid); end
      tests++; if (Tap_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", Tap_err); end
   endtask

   task automatic test_tap4();
      logic [7:0] eq;
      logic       ev;
      Tap = 4'd4;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, 8'(i), 1'b0);
         ev = (i >= 4);
         eq = ev ? 8'(i - 4) : 8'h00;
         tests++; if (Q_valid !== ev) begin fails++; $display("FAIL tap4_qv i=%0d got %b exp %b", i, Q_valid, ev); end
         tests++; if (Q !== eq) begin fails++; $display("FAIL tap4_q i=%0d got %h exp %h", i, Q, eq); end
         tests++; if (Tap_err !== 1'b0) begin fails++; $display("FAIL tap4_err i=%0d got %b exp 0", i, Tap_err); end
      end
   endtask

   task automatic test_tap_change();
      logic [7:0] eq;
      logic       ev;
      Tap = 4'd4;
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'(i), 1'b0);
      Tap = 4'd15;
      // history is 4 here, so accepts 4..14 stay invalid, then Din-15 across wraps
      for (int i = 4; i < 50; i++) begin
         cycle(1'b1, 8'(i), 1'b0);
         ev = (i >= 15);
         eq = ev ? 8'(i - 15) : 8'h00;
         tests++; if (Q_valid !== ev) begin fails++; $display("FAIL tapchg_qv i=%0d got %b exp %b", i, Q_valid, ev); end
         tests++; if (Q !== eq) begin fails++; $display("FAIL tapchg_q i=%0d got %h exp %h", i, Q, eq); end
      end
   endtask

   task automatic test_tap_zero();
      logic [7:0] eq;
      logic       ev;
      Tap = 4'd0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 8'(i), 1'b0);
         ev = (i >= 1);
         eq = ev ? 8'(i - 1) : 8'h00;
         tests++; if (Tap_err !== 1'b1) begin fails++; $display("FAIL tap0_err i=%0d got %b exp 1", i, Tap_err); end
         tests++; if (Q_valid !== ev) begin fails++; $display("FAIL tap0_qv i=%0d got %b exp %b", i, Q_valid, ev); end
         tests++; if (Q !== eq) begin fails++; $display("FAIL tap0_q i=%0d got %h exp %h", i, Q, eq); end
      end
   endtask

   task automatic test_reset_midstream();
      logic [7:0] eq;
      logic       ev;
      int         i;
      Tap = 4'd4;
      do_reset();
      i = 0;
      while ($time < 3000) begin
         cycle(1'b1, 8'(i), 1'b0);
         i++;
      end
      tests++; if (Q_valid !== 1'b1) begin fails++; $display("FAIL midrst_run_qv got %b exp 1", Q_valid); end
      #2;
      Reset     = 1'b1;
      Din_valid = 1'b0;
      #1;
      tests++; if (Q !== 8'h00)      begin fails++; $display("FAIL midrst_q got %h exp 00", Q); end
      tests++; if (Q_valid !== 1'b0) begin fails++; $display("FAIL midrst_qv got %b exp 0", Q_valid); end
      @(negedge Clock);
      Reset = 1'b0;
      for (int j = 0; j < 8; j++) begin
         cycle(1'b1, 8'h80 + 8'(j), 1'b0);
         ev = (j >= 4);
         eq = ev ? 8'h80 + 8'(j - 4) : 8'h00;
         tests++; if (Q_valid !== ev) begin fails++; $display("FAIL midrst_post_qv j=%0d got %b exp %b", j, Q_valid, ev); end
         tests++; if (Q !== eq) begin fails++; $display("FAIL midrst_post_q j=%0d got %h exp %h", j, Q, eq); end
      end
   endtask

   task automatic test_flush();
      logic [7:0] eq;
      logic       ev;
      Tap = 4'd4;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 8'h10 + 8'(i), 1'b0);
         ev = (i >= 4);
         eq = ev ? 8'h10 + 8'(i - 4) : 8'h00;
         tests++; if (Q !== eq) begin fails++; $display("FAIL flush_pre_q i=%0d got %h exp %h", i, Q, eq); end
      end
      cycle(1'b1, 8'h20, 1'b1);
      tests++; if (Q_valid !== 1'b0) begin fails++; $display("FAIL flush_qv got %b exp 0", Q_valid); end
      tests++; if (Q !== 8'h15)      begin fails++; $display("FAIL flush_hold_q got %h exp 15", Q); end
      for (int j = 0; j < 12; j++) begin
         cycle(1'b1, 8'h21 + 8'(j), 1'b0);
         ev = (j >= 4);
         eq = ev ? 8'h21 + 8'(j - 4) : 8'h15;
         tests++; if (Q_valid !== ev) begin fails++; $display("FAIL flush_post_qv j=%0d got %b exp %b", j, Q_valid, ev); end
         tests++; if (Q !== eq) begin fails++; $display("FAIL flush_post_q j=%0d got %h exp %h", j, Q, eq); end
         tests++; if (Q === 8'h20) begin fails++; $display("FAIL flush_discard j=%0d got %h exp not 20", j, Q); end
      end
   endtask

   task automatic test_gapped();
      logic [7:0] eq;
      logic       ev;
      Tap = 4'd3;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         cycle(1'b1, 8'h40 + 8'(k), 1'b0);
         ev = (k >= 3);
         eq = ev ? 8'h40 + 8'(k - 3) : 8'h00;
         tests++; if (Q_valid !== ev) begin fails++; $display("FAIL gap_qv k=%0d got %b exp %b", k, Q_valid, ev); end
         tests++; if (Q !== eq) begin fails++; $display("FAIL gap_q k=%0d got %h exp %h", k, Q, eq); end
         for (int g = 0; g < 2; g++) begin
            cycle(1'b0, 8'hEE, 1'b0);
            tests++; if (Q_valid !== 1'b0) begin fails++; $display("FAIL gap_idle_qv k=%0d got %b exp 0", k, Q_valid); end
            tests++; if (Q !== eq) begin fails++; $display("FAIL gap_idle_q k=%0d got %h exp %h", k, Q, eq); end
         end
      end
   endtask

   initial begin
      Reset     = 1'b1;
      Din_valid = 1'b0;
      Din       = 8'h00;
      Flush     = 1'b0;
      Tap       = 4'd4;
      test_reset();
      test_tap4();
      test_tap_change();
      test_tap_zero();
      test_reset_midstream();
      test_flush();
      test_gapped();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
